// File: rtl/checker_ctrl_if.sv
// Bus between the checker controller and the checker mode units:
// mode selection/address/start out, completion pulses and result back.
interface checker_ctrl_if;
  logic [1:0]  mode_mode;
  logic [63:0] mode_addr;
  logic        mode_start;
  logic        mode_end;
  logic        mode_error;
  logic [63:0] mode_data;

  modport master (
    output mode_mode, mode_addr, mode_start,
    input  mode_end, mode_error, mode_data
  );

  modport slave (
    input  mode_mode, mode_addr, mode_start,
    output mode_end, mode_error, mode_data
  );
endinterface

// File: rtl/checker_ctrl.sv
// Checker run controller: launches a mode unit, watches for end/error/timeout,
// raises irq until acknowledged and optionally re-runs after a fixed idle period.
module checker_ctrl #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [1:0]           ctrl_mode,
  input  logic [63:0]          ctrl_addr,
  input  logic [CNT_WIDTH-1:0] ctrl_period,
  input  logic [CNT_WIDTH-1:0] ctrl_timeout,
  input  logic                 ctrl_start,
  input  logic                 ctrl_abort,
  input  logic                 ctrl_ack,
  output logic                 ctrl_busy,
  output logic                 ctrl_done,
  output logic                 ctrl_error,
  output logic                 ctrl_tmo,
  output logic                 irq,
  output logic [63:0]          ctrl_data,
  output logic [15:0]          ctrl_runs,
  checker_ctrl_if.master       mode
);

  typedef enum logic [1:0] {IDLE, RUN, IRQ, PERIOD} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state, nxt_state;
  logic [1:0]           mode_r, nxt_mode;
  logic [63:0]          addr_r, nxt_addr;
  logic [CNT_WIDTH-1:0] period_r, nxt_period;
  logic [CNT_WIDTH-1:0] timeout_r, nxt_timeout;
  logic [CNT_WIDTH-1:0] cnt, nxt_cnt;
  logic [63:0]          data_r, nxt_data;
  logic                 done_r, nxt_done;
  logic                 err_r, nxt_err;
  logic                 tmo_r, nxt_tmo;
  logic [15:0]          runs_r, nxt_runs;
  logic [15:0]          runs_inc;

  assign runs_inc = (runs_r == '1) ? runs_r : runs_r + 16'd1;

  // One counter serves as the RUN timeout up-counter and the PERIOD down-counter;
  // the two states never overlap so the value is simply reloaded on each entry.
  always_comb begin
    nxt_state   = state;
    nxt_mode    = mode_r;
    nxt_addr    = addr_r;
    nxt_period  = period_r;
    nxt_timeout = timeout_r;
    nxt_cnt     = cnt;
    nxt_data    = data_r;
    nxt_done    = done_r;
    nxt_err     = err_r;
    nxt_tmo     = tmo_r;
    nxt_runs    = runs_r;
    case (state)
      IDLE: begin
        if (ctrl_start && !ctrl_abort) begin
          nxt_mode    = ctrl_mode;
          nxt_addr    = ctrl_addr;
          nxt_period  = ctrl_period;
          nxt_timeout = ctrl_timeout;
          nxt_done    = 1'b0;
          nxt_err     = 1'b0;
          nxt_tmo     = 1'b0;
          nxt_cnt     = '0;
          nxt_state   = RUN;
        end
      end
      RUN: begin
        if (ctrl_abort) begin
          nxt_state = IDLE;
        end else if (mode.mode_end) begin
          nxt_data  = mode.mode_data;
          nxt_done  = 1'b1;
          nxt_runs  = runs_inc;
          nxt_state = IRQ;
        end else if (mode.mode_error) begin
          nxt_err   = 1'b1;
          nxt_runs  = runs_inc;
          nxt_state = IRQ;
        end else if (timeout_r != '0 && cnt == timeout_r - CNT_ONE) begin
          nxt_tmo   = 1'b1;
          nxt_runs  = runs_inc;
          nxt_state = IRQ;
        end else begin
          nxt_cnt = cnt + CNT_ONE;
        end
      end
      IRQ: begin
        if (ctrl_abort) begin
          nxt_state = IDLE;
        end else if (ctrl_ack) begin
          if (period_r == '0) begin
            nxt_state = IDLE;
          end else begin
            nxt_cnt   = period_r - CNT_ONE;
            nxt_state = PERIOD;
          end
        end
      end
      PERIOD: begin
        if (ctrl_abort) begin
          nxt_state = IDLE;
        end else if (cnt == '0) begin
          nxt_done  = 1'b0;
          nxt_err   = 1'b0;
          nxt_tmo   = 1'b0;
          nxt_state = RUN;
        end else begin
          nxt_cnt = cnt - CNT_ONE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      mode_r    <= '0;
      addr_r    <= '0;
      period_r  <= '0;
      timeout_r <= '0;
      cnt       <= '0;
      data_r    <= '0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      tmo_r     <= 1'b0;
      runs_r    <= '0;
    end else begin
      state     <= nxt_state;
      mode_r    <= nxt_mode;
      addr_r    <= nxt_addr;
      period_r  <= nxt_period;
      timeout_r <= nxt_timeout;
      cnt       <= nxt_cnt;
      data_r    <= nxt_data;
      done_r    <= nxt_done;
      err_r     <= nxt_err;
      tmo_r     <= nxt_tmo;
      runs_r    <= nxt_runs;
    end
  end

  assign mode.mode_start = (state == RUN);
  assign mode.mode_mode  = mode_r;
  assign mode.mode_addr  = addr_r;
  assign irq             = (state == IRQ);
  assign ctrl_busy       = (state != IDLE);
  assign ctrl_done       = done_r;
  assign ctrl_error      = err_r;
  assign ctrl_tmo        = tmo_r;
  assign ctrl_data       = data_r;
  assign ctrl_runs       = runs_r;

endmodule

// File: tb/tb_checker_ctrl.sv
// Directed bench for checker_ctrl: result data is checked through a scoreboard
// queue, status/timing against values tracked by the bench.
module tb_checker_ctrl;
  localparam int unsigned CW = 32;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic [1:0]    ctrl_mode;
  logic [63:0]   ctrl_addr;
  logic [CW-1:0] ctrl_period, ctrl_timeout;
  logic          ctrl_start, ctrl_abort, ctrl_ack;
  logic          ctrl_busy, ctrl_done, ctrl_error, ctrl_tmo, irq;
  logic [63:0]   ctrl_data;
  logic [15:0]   ctrl_runs;

  checker_ctrl_if mif ();

  checker_ctrl #(.CNT_WIDTH(CW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .ctrl_mode(ctrl_mode), .ctrl_addr(ctrl_addr),
    .ctrl_period(ctrl_period), .ctrl_timeout(ctrl_timeout),
    .ctrl_start(ctrl_start), .ctrl_abort(ctrl_abort), .ctrl_ack(ctrl_ack),
    .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done), .ctrl_error(ctrl_error),
    .ctrl_tmo(ctrl_tmo), .irq(irq), .ctrl_data(ctrl_data), .ctrl_runs(ctrl_runs),
    .mode(mif)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned exp_runs = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag);
    logic [63:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    chk(tag, ctrl_data, e);
    last_data = e;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [63:0] a,
                          input logic [CW-1:0] per, input logic [CW-1:0] tmo);
    ctrl_mode = m; ctrl_addr = a; ctrl_period = per; ctrl_timeout = tmo;
    ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0;
  endtask

  task automatic do_ack();
    ctrl_ack = 1'b1;
    tick();
    ctrl_ack = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(ctrl_busy), 64'd0);
    chk({tag, "_irq"}, 64'(irq), 64'd0);
    chk({tag, "_mstart"}, 64'(mif.mode_start), 64'd0);
    chk({tag, "_flags"}, 64'({ctrl_done, ctrl_error, ctrl_tmo}), 64'd0);
    chk({tag, "_data"}, ctrl_data, 64'd0);
    chk({tag, "_runs"}, 64'(ctrl_runs), 64'd0);
    chk({tag, "_mmode"}, 64'(mif.mode_mode), 64'd0);
    chk({tag, "_maddr"}, mif.mode_addr, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    sys_rst = 1'b1; ctrl_mode = '0; ctrl_addr = '0; ctrl_period = '0; ctrl_timeout = '0;
    ctrl_start = 1'b0; ctrl_abort = 1'b0; ctrl_ack = 1'b0;
    mif.mode_end = 1'b0; mif.mode_error = 1'b0; mif.mode_data = '0;
    tick(); tick();
    sys_rst = 1'b0;
    chk_zero("reset");

    // Basic one-shot run ending after 10 cycles
    do_start(2'd2, 64'h1000, '0, '0);
    chk("t1_mmode", 64'(mif.mode_mode), 64'd2);
    chk("t1_maddr", mif.mode_addr, 64'h1000);
    chk("t1_busy", 64'(ctrl_busy), 64'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (mif.mode_start) n++;
      if (i == 9) begin
        mif.mode_end = 1'b1; mif.mode_data = 64'hDEADBEEF;
        exp_q.push_back(64'hDEADBEEF);
      end
      tick();
      mif.mode_end = 1'b0;
    end
    exp_runs++;
    chk("t1_hi_cycles", 64'(n), 64'd10);
    chk("t1_mstart_low", 64'(mif.mode_start), 64'd0);
    chk("t1_done", 64'(ctrl_done), 64'd1);
    sb_pop("t1_data");
    chk("t1_runs", 64'(ctrl_runs), 64'(exp_runs));
    tick(); tick();
    chk("t1_irq_hold", 64'(irq), 64'd1);
    do_ack();
    chk("t1_idle_busy", 64'(ctrl_busy), 64'd0);
    chk("t1_idle_irq", 64'(irq), 64'd0);
    chk("t1_done_kept", 64'(ctrl_done), 64'd1);

    // Timeout with no response
    do_start(2'd1, 64'h2000, '0, 32'd5);
    chk("t2_done_cleared", 64'(ctrl_done), 64'd0);
    n = 0;
    while (mif.mode_start && n < 20) begin n++; tick(); end
    exp_runs++;
    chk("t2_hi_cycles", 64'(n), 64'd5);
    chk("t2_tmo", 64'(ctrl_tmo), 64'd1);
    chk("t2_irq", 64'(irq), 64'd1);
    chk("t2_done", 64'(ctrl_done), 64'd0);
    chk("t2_runs", 64'(ctrl_runs), 64'(exp_runs));
    chk("t2_data_kept", ctrl_data, last_data);
    do_ack();

    // end and error together: end wins
    do_start(2'd3, 64'h3000, '0, '0);
    mif.mode_end = 1'b1; mif.mode_error = 1'b1; mif.mode_data = 64'h1234_5678_9ABC_DEF0;
    exp_q.push_back(64'h1234_5678_9ABC_DEF0);
    tick();
    mif.mode_end = 1'b0; mif.mode_error = 1'b0;
    exp_runs++;
    chk("t3a_done", 64'(ctrl_done), 64'd1);
    chk("t3a_error", 64'(ctrl_error), 64'd0);
    sb_pop("t3a_data");
    do_ack();

    // end on the last timeout cycle: end wins over timeout
    do_start(2'd0, 64'h4000, '0, 32'd4);
    tick(); tick(); tick();
    chk("t3b_still_run", 64'(mif.mode_start), 64'd1);
    mif.mode_end = 1'b1; mif.mode_data = 64'hCAFE_F00D;
    exp_q.push_back(64'hCAFE_F00D);
    tick();
    mif.mode_end = 1'b0;
    exp_runs++;
    chk("t3b_done", 64'(ctrl_done), 64'd1);
    chk("t3b_tmo", 64'(ctrl_tmo), 64'd0);
    sb_pop("t3b_data");
    do_ack();

    // error alone leaves the data register untouched
    do_start(2'd1, 64'h5000, '0, '0);
    mif.mode_error = 1'b1; mif.mode_data = 64'h5555_5555;
    tick();
    mif.mode_error = 1'b0;
    exp_runs++;
    chk("t3c_error", 64'(ctrl_error), 64'd1);
    chk("t3c_done", 64'(ctrl_done), 64'd0);
    chk("t3c_data_kept", ctrl_data, last_data);
    chk("t3c_runs", 64'(ctrl_runs), 64'(exp_runs));
    do_ack();

    // Periodic re-runs with period 3, abort during the last PERIOD
    do_start(2'd2, 64'h6000, 32'd3, '0);
    for (int r = 0; r < 3; r++) begin
      chk($sformatf("t4_run%0d_mstart", r), 64'(mif.mode_start), 64'd1);
      tick();
      mif.mode_end = 1'b1; mif.mode_data = 64'h100 + 64'(r);
      exp_q.push_back(64'h100 + 64'(r));
      tick();
      mif.mode_end = 1'b0;
      exp_runs++;
      chk($sformatf("t4_run%0d_done", r), 64'(ctrl_done), 64'd1);
      sb_pop($sformatf("t4_run%0d_data", r));
      chk($sformatf("t4_run%0d_runs", r), 64'(ctrl_runs), 64'(exp_runs));
      do_ack();
      if (r < 2) begin
        n = 0;
        while (!mif.mode_start && n < 10) begin n++; tick(); end
        chk($sformatf("t4_run%0d_gap", r), 64'(n), 64'd3);
        chk($sformatf("t4_run%0d_done_clr", r), 64'(ctrl_done), 64'd0);
      end
    end
    chk("t4_period_busy", 64'(ctrl_busy), 64'd1);
    tick();
    ctrl_abort = 1'b1;
    tick();
    ctrl_abort = 1'b0;
    chk("t5p_busy", 64'(ctrl_busy), 64'd0);
    chk("t5p_mstart", 64'(mif.mode_start), 64'd0);
    chk("t5p_done_kept", 64'(ctrl_done), 64'd1);
    chk("t5p_runs_kept", 64'(ctrl_runs), 64'(exp_runs));
    tick(); tick();
    chk("t5p_no_rerun", 64'(mif.mode_start), 64'd0);

    // start during RUN ignored, then abort in RUN
    do_start(2'd1, 64'hABC, '0, '0);
    do_start(2'd3, 64'hFFFF, '0, '0);
    chk("t5r_mmode_kept", 64'(mif.mode_mode), 64'd1);
    chk("t5r_maddr_kept", mif.mode_addr, 64'hABC);
    chk("t5r_run", 64'(mif.mode_start), 64'd1);
    ctrl_abort = 1'b1;
    tick();
    ctrl_abort = 1'b0;
    chk("t5r_busy", 64'(ctrl_busy), 64'd0);
    chk("t5r_mstart", 64'(mif.mode_start), 64'd0);
    chk("t5r_irq", 64'(irq), 64'd0);
    chk("t5r_runs_kept", 64'(ctrl_runs), 64'(exp_runs));
    chk("t5r_data_kept", ctrl_data, last_data);

    // Reset while in IRQ with runs=7
    sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    exp_runs = 0; last_data = '0;
    chk_zero("reset2");
    while (exp_runs < 6) begin
      do_start(2'd0, 64'h7000, '0, 32'd1);
      tick();
      exp_runs++;
      do_ack();
    end
    do_start(2'd0, 64'h7000, '0, 32'd1);
    tick();
    exp_runs++;
    chk("t6_runs7", 64'(ctrl_runs), 64'd7);
    chk("t6_irq", 64'(irq), 64'd1);
    sys_rst = 1'b1;
    tick();
    chk_zero("t6_rst");
    sys_rst = 1'b0;
    do_start(2'd2, 64'h8000, '0, '0);
    chk("t6_restart_busy", 64'(ctrl_busy), 64'd1);
    chk("t6_restart_mstart", 64'(mif.mode_start), 64'd1);
    chk("t6_restart_maddr", mif.mode_addr, 64'h8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/checker_ctrl.md
CHECKER_CTRL -- requirements
Module: checker_ctrl

Interface
REQ-001 SHALL have parameter: CNT_WIDTH, 32, width of the timeout and period counters.
REQ-002 SHALL have port: sys_clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: sys_rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: ctrl_mode  in  2  checker mode to run; latched on accepted start.
REQ-005 SHALL have port: ctrl_addr  in  64  target address; latched on accepted start.
REQ-006 SHALL have port: ctrl_period  in  CNT_WIDTH  idle cycles between automatic re-runs; 0 = one-shot; latched on start.
REQ-007 SHALL have port: ctrl_timeout  in  CNT_WIDTH  max RUN cycles; 0 = no timeout; latched on start.
REQ-008 SHALL have ports: ctrl_start, ctrl_abort, ctrl_ack  in  1 each  single-cycle command pulses.
REQ-009 SHALL have ports: ctrl_busy, ctrl_done, ctrl_error, ctrl_tmo, irq  out  1 each  status flags.
REQ-010 SHALL have ports: ctrl_data  out  64  last captured result; ctrl_runs  out  16  completed-run count.
REQ-011 SHALL have ports: mode_mode  out  2; mode_addr  out  64; mode_start  out  1  drive to checker mode units.
REQ-012 SHALL have ports: mode_end, mode_error  in  1  one-cycle completion pulses; mode_data  in  64  result.

Function
REQ-013 SHALL implement states IDLE, RUN, IRQ, PERIOD.
REQ-014 IDLE: ctrl_start with ctrl_abort low SHALL latch mode/addr/period/timeout, clear done/error/tmo, zero timeout counter, enter RUN next cycle.
REQ-015 mode_mode/mode_addr SHALL present latched values from the cycle after start until next accepted start.
REQ-016 mode_start SHALL be 1 exactly while in RUN and 0 in every other state.
REQ-017 RUN: timeout counter SHALL increment every cycle; wraps never matter since compare is exact equality.
REQ-018 RUN, mode_end=1: SHALL capture mode_data into ctrl_data, set done, enter IRQ.
REQ-019 RUN, mode_error=1 and mode_end=0: SHALL set error, enter IRQ; ctrl_data unchanged.
REQ-020 RUN, timeout!=0 and counter==timeout-1 with no end/error: SHALL set tmo, enter IRQ (RUN lasts exactly ctrl_timeout cycles).
REQ-021 Priority on simultaneous events in RUN: abort > mode_end > mode_error > timeout.
REQ-022 Each RUN exit via end/error/timeout SHALL increment ctrl_runs, saturating at 16'hFFFF.
REQ-023 IRQ: irq SHALL be 1; on ctrl_ack go to IDLE if period==0, else to PERIOD with counter loaded to period-1.
REQ-024 PERIOD: counter SHALL decrement; at 0 SHALL clear done/error/tmo, zero timeout counter, enter RUN.
REQ-025 ctrl_abort in RUN/IRQ/PERIOD SHALL enter IDLE next cycle, drop mode_start and irq, leave flags/data/runs unchanged.
REQ-026 ctrl_start outside IDLE SHALL be ignored; ctrl_ack outside IRQ SHALL be ignored.
REQ-027 ctrl_busy SHALL be 1 in every state except IDLE.
REQ-028 mode_start SHALL be low at least one cycle between consecutive runs (guaranteed by IRQ >= 1 cycle).

Reset
REQ-029 sys_rst=1 SHALL force IDLE and zero all outputs (mode_start, irq, busy, flags, ctrl_data, ctrl_runs, mode_mode, mode_addr) next edge, from any state.
REQ-030 Initial state at power-up SHALL equal reset state.

Verification
REQ-031 start mode=2 addr=0x1000 timeout=0 period=0; mode_end after 10 cycles, mode_data=0xDEADBEEF -> mode_start high 10 cycles, done=1, ctrl_data=0xDEADBEEF, irq=1 until ack, runs=1, IDLE.
REQ-032 timeout=5, no response -> mode_start high exactly 5 cycles, tmo=1, irq=1, done=0, runs=1.
REQ-033 mode_end and mode_error same cycle -> done=1, error=0; mode_end at timeout cycle -> done=1, tmo=0.
REQ-034 period=3, mode_end each run, ack each irq -> mode_start re-asserts 3 cycles after ack, done cleared on re-entry, runs increments per run.
REQ-035 abort during RUN and during PERIOD -> IDLE next cycle, mode_start=0, irq=0, busy=0; start during RUN ignored.
REQ-036 sys_rst in IRQ with runs=7 -> all outputs 0, runs=0, start accepted the cycle after reset releases.
